// File: rtl/mult8_seq_control.sv
// -----------------------------------------------------------------------------
// mult8_seq_control
//
// This is the sequencer and register file for an 8x8 signed (two's-complement)
// shift-add multiplier. It holds the X:A:B product chain and the latched
// multiplicand M. It runs eight add/shift iterations and finishes with the
// 16-bit product in A:B. X is the product's sign-extension bit.
//
// The 9-bit add/subtract stage is external. This block drives that stage with
// Add_A/Add_B/Subtract and captures its sign-extended Sum in ADD cycles.
//
// Ports:
//   Clk           in   system clock, rising-edge active
//   Reset_n       in   asynchronous active-low reset
//   Run           in   start request (level, sampled in IDLE)
//   ClearA_LoadB  in   in IDLE: clear X/A and load B from Switches
//   Switches[7:0] in   multiplier (on load) / multiplicand (on start)
//   Sum[8:0]      in   sign-extended result of the add/subtract stage
//   Add_A[7:0]    out  adder operand A (= A register)
//   Add_B[7:0]    out  adder operand B (= latched multiplicand M)
//   Subtract      out  1 = adder computes A - M
//   Xval          out  X register
//   Aval[7:0]     out  A register (product high byte)
//   Bval[7:0]     out  B register (product low byte / multiplier)
//   Done          out  high while in DONE
// -----------------------------------------------------------------------------
module mult8_seq_control (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Switches,
    input  logic [8:0] Sum,
    output logic [7:0] Add_A,
    output logic [7:0] Add_B,
    output logic       Subtract,
    output logic       Xval,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       x_q;
    logic [7:0] a_q, b_q, m_q;
    logic [2:0] cnt_q;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples pre-edge values. Blocking here would make the result depend on
    // statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: next_state gets a default before the case. Without it, any path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!ClearA_LoadB && Run) state_nxt = ADD;  // load wins over start
            ADD:   state_nxt = SHIFT;
            SHIFT: state_nxt = (cnt_q == 3'd7) ? DONE : ADD;
            DONE:  if (!Run) state_nxt = IDLE;                  // no auto-restart
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q   <= 1'b0;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            m_q   <= 8'h00;
            cnt_q <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        x_q <= 1'b0;
                        a_q <= 8'h00;
                        b_q <= Switches;
                    end else if (Run) begin
                        // B is kept, so back-to-back runs reuse the previous
                        // low product byte as the multiplier.
                        x_q   <= 1'b0;
                        a_q   <= 8'h00;
                        m_q   <= Switches;
                        cnt_q <= 3'd0;
                    end
                end
                ADD: begin
                    if (b_q[0]) {x_q, a_q} <= Sum;
                end
                SHIFT: begin
                    // Arithmetic right shift of X:A:B. X is duplicated into A[7].
                    a_q   <= {x_q, a_q[7:1]};
                    b_q   <= {a_q[0], b_q[7:1]};
                    cnt_q <= cnt_q + 3'd1;          // wraps to 0 leaving the 8th SHIFT
                end
                DONE: ;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    // The multiplier's sign bit has weight -2^7. So the last partial product
    // is subtracted instead of added.
    assign Subtract = (state == ADD) && (cnt_q == 3'd7);
    assign Add_A    = a_q;
    assign Add_B    = m_q;
    assign Xval     = x_q;
    assign Aval     = a_q;
    assign Bval     = b_q;
    assign Done     = (state == DONE);

endmodule
